// File: rtl/egress_port.sv
// egress_port: descriptor queue plus packet-buffer reader.
// Streams each frame's payload through a 2-entry flow-through FIFO.
module egress_port #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 10,
    parameter int Q_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write_req_i,
    input  logic [ADDR_W-1:0]        start_ptr_i,
    output logic                     rd_req_o,
    output logic [ADDR_W-1:0]        rd_addr_o,
    input  logic                     rd_gnt_i,
    input  logic [DATA_W-1:0]        rd_data_i,
    output logic [DATA_W-1:0]        tx_data_o,
    output logic                     tx_valid_o,
    output logic                     tx_last_o,
    input  logic                     tx_ready_i,
    output logic                     release_o,
    output logic [ADDR_W-1:0]        release_ptr_o,
    output logic                     overflow_o,
    output logic [$clog2(Q_DEPTH):0] q_count_o
);

    localparam int QW = $clog2(Q_DEPTH);
    localparam int CW = QW + 1;
    localparam logic [CW-1:0] QFULL = CW'(Q_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        HDR_WAIT,
        PAYLOAD,
        RELEASE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // descriptor queue
    logic [ADDR_W-1:0] r_q_mem [Q_DEPTH];
    logic [QW-1:0]     r_q_wr;
    logic [QW-1:0]     r_q_rd;
    logic [CW-1:0]     r_q_cnt;
    logic              r_overflow;
    logic              w_q_full;
    logic              w_q_empty;
    logic              w_enq;
    logic              w_deq;
    logic              w_drop;

    // frame read engine
    logic [ADDR_W-1:0] r_cur_ptr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [LEN_W-1:0]  r_rd_left;
    logic [LEN_W-1:0]  r_tx_left;
    logic              r_rd_pend;
    logic              w_rd_req;
    logic              w_rd_fire;
    logic              w_pay_fire;
    logic              w_release;
    logic [LEN_W-1:0]  w_hdr_len;

    // output FIFO
    logic [DATA_W-1:0] r_ob_mem [2];
    logic              r_ob_head;
    logic [1:0]        r_ob_cnt;
    logic [1:0]        w_occ;
    logic              w_ob_push;
    logic              w_ob_pop;
    logic              w_tx_valid;
    logic              w_tx_fire;
    logic              w_tx_last;
    logic [DATA_W-1:0] w_tx_data;

    // A dequeue in the same cycle frees a slot, so full+deq still accepts.
    assign w_q_full  = (r_q_cnt == QFULL);
    assign w_q_empty = (r_q_cnt == '0);
    assign w_enq     = write_req_i && (!w_q_full || w_deq);
    assign w_drop    = write_req_i && !w_enq;

    assign w_hdr_len  = rd_data_i[LEN_W-1:0];
    assign w_rd_fire  = w_rd_req && rd_gnt_i;
    assign w_pay_fire = w_rd_fire && (r_state == PAYLOAD);

    // Words still owed to the output path: buffered plus the one in flight.
    assign w_occ = r_ob_cnt + {1'b0, r_rd_pend};

    // Empty FIFO lets returning data straight through to the sink.
    assign w_tx_valid = (r_ob_cnt != 2'd0) || r_rd_pend;
    assign w_tx_data  = (r_ob_cnt != 2'd0) ? r_ob_mem[r_ob_head] : rd_data_i;
    assign w_tx_fire  = w_tx_valid && tx_ready_i;
    assign w_tx_last  = w_tx_valid && (r_tx_left == LEN_W'(1));
    assign w_ob_pop   = w_tx_fire && (r_ob_cnt != 2'd0);
    assign w_ob_push  = r_rd_pend && !((r_ob_cnt == 2'd0) && tx_ready_i);

    // Descriptor storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_mem[r_q_wr] <= start_ptr_i;
        end
    end

    // Descriptor queue pointers, occupancy and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_wr     <= '0;
            r_q_rd     <= '0;
            r_q_cnt    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_enq) begin
                r_q_wr <= r_q_wr + QW'(1);
            end
            if (w_deq) begin
                r_q_rd <= r_q_rd + QW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_q_cnt <= r_q_cnt + CW'(1);
                2'b01:   r_q_cnt <= r_q_cnt - CW'(1);
                default: r_q_cnt <= r_q_cnt;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state, read request, dequeue and release strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_req    = 1'b0;
        w_deq       = 1'b0;
        w_release   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_q_empty) begin
                    w_deq       = 1'b1;
                    w_state_nxt = HDR;
                end
            end
            HDR: begin
                w_rd_req = 1'b1;
                if (rd_gnt_i) begin
                    w_state_nxt = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                if (w_hdr_len == '0) begin
                    w_state_nxt = RELEASE;
                end else begin
                    w_state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                w_rd_req = (r_rd_left != '0) && (w_occ < 2'd2);
                if (w_tx_fire && (r_tx_left == LEN_W'(1))) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                w_release   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Frame pointer, read address, read/tx countdowns, in-flight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_ptr <= '0;
            r_rd_addr <= '0;
            r_rd_left <= '0;
            r_tx_left <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_pay_fire;
            if (w_deq) begin
                r_cur_ptr <= r_q_mem[r_q_rd];
                r_rd_addr <= r_q_mem[r_q_rd];
            end
            if (r_state == HDR_WAIT) begin
                r_rd_left <= w_hdr_len;
                r_tx_left <= w_hdr_len;
                r_rd_addr <= r_cur_ptr + ADDR_W'(1);
            end else begin
                if (w_pay_fire) begin
                    r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    r_rd_left <= r_rd_left - LEN_W'(1);
                end
                if (w_tx_fire) begin
                    r_tx_left <= r_tx_left - LEN_W'(1);
                end
            end
        end
    end

    // Output FIFO storage; the tail sits one past the head when occupied.
    always_ff @(posedge clk) begin
        if (w_ob_push) begin
            r_ob_mem[r_ob_head ^ r_ob_cnt[0]] <= rd_data_i;
        end
    end

    // Output FIFO head and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ob_head <= 1'b0;
            r_ob_cnt  <= 2'd0;
        end else begin
            if (w_ob_pop) begin
                r_ob_head <= ~r_ob_head;
            end
            case ({w_ob_push, w_ob_pop})
                2'b10:   r_ob_cnt <= r_ob_cnt + 2'd1;
                2'b01:   r_ob_cnt <= r_ob_cnt - 2'd1;
                default: r_ob_cnt <= r_ob_cnt;
            endcase
        end
    end

    // Data-bearing outputs read zero whenever their strobe is low.
    assign rd_req_o      = w_rd_req;
    assign rd_addr_o     = w_rd_req ? r_rd_addr : '0;
    assign tx_valid_o    = w_tx_valid;
    assign tx_data_o     = w_tx_valid ? w_tx_data : '0;
    assign tx_last_o     = w_tx_last;
    assign release_o     = w_release;
    assign release_ptr_o = w_release ? r_cur_ptr : '0;
    assign overflow_o    = r_overflow;
    assign q_count_o     = r_q_cnt;

endmodule

// File: tb/tb_egress_port.sv
// tb_egress_port: directed and random frames against a
// queue-based frame model of the egress port.
module tb_egress_port;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 10;
    localparam int QD = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 write_req_i;
    logic [AW-1:0]        start_ptr_i;
    logic                 rd_req_o;
    logic [AW-1:0]        rd_addr_o;
    logic                 rd_gnt_i;
    logic [DW-1:0]        rd_data_i;
    logic [DW-1:0]        tx_data_o;
    logic                 tx_valid_o;
    logic                 tx_last_o;
    logic                 tx_ready_i;
    logic                 release_o;
    logic [AW-1:0]        release_ptr_o;
    logic                 overflow_o;
    logic [$clog2(QD):0]  q_count_o;

    egress_port #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .LEN_W   (LW),
        .Q_DEPTH (QD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_req_i   (write_req_i),
        .start_ptr_i   (start_ptr_i),
        .rd_req_o      (rd_req_o),
        .rd_addr_o     (rd_addr_o),
        .rd_gnt_i      (rd_gnt_i),
        .rd_data_i     (rd_data_i),
        .tx_data_o     (tx_data_o),
        .tx_valid_o    (tx_valid_o),
        .tx_last_o     (tx_last_o),
        .tx_ready_i    (tx_ready_i),
        .release_o     (release_o),
        .release_ptr_o (release_ptr_o),
        .overflow_o    (overflow_o),
        .q_count_o     (q_count_o)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int gnt_mode = 1;
    int rdy_mode = 0;

    logic [DW-1:0] mem [1024];

    // model state
    logic [AW-1:0] exp_frames [$];
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_words [$];
    bit            in_frame = 1'b0;
    logic [AW-1:0] cur_ptr;
    int            rd_idx = 0;
    int            beats = 0;
    int            nrel = 0;
    int            novf = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    bit            prev_hdr_gnt = 1'b0;
    int            first_valid_cyc = -1;
    int            hdr_gnt_cyc = 0;
    int            rel_cyc = 0;
    int            ovf_cyc = 0;
    bit            g_pend = 1'b0;
    logic [AW-1:0] g_addr;

    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_words [$];
    logic [AW-1:0] log_rel [$];

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint exp);
        ncmp++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic start_frame(input logic [AW-1:0] p);
        int len;
        len = int'(mem[p][LW-1:0]);
        in_frame = 1'b1;
        cur_ptr = p;
        rd_idx = 0;
        beats = 0;
        exp_addr.delete();
        exp_words.delete();
        for (int k = 0; k <= len; k++)
            exp_addr.push_back(AW'(p + AW'(k)));
        for (int k = 1; k <= len; k++)
            exp_words.push_back(mem[AW'(p + AW'(k))]);
    endtask

    always @(posedge clk) cyc++;

    // memory and sink responder
    always @(posedge clk) begin
        #1;
        rd_data_i = g_pend ? mem[g_addr] : DW'($urandom);
        case (gnt_mode)
            0: rd_gnt_i = 1'b0;
            1: rd_gnt_i = 1'b1;
            default: rd_gnt_i = ($urandom_range(0, 3) != 0);
        endcase
        case (rdy_mode)
            0: tx_ready_i = 1'b1;
            1: tx_ready_i = ~tx_ready_i;
            default: tx_ready_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    // compare process
    always @(negedge clk) begin
        g_pend = 1'b0;
        if (!rst_n) begin
            chk({rd_req_o, tx_valid_o, tx_last_o, release_o, overflow_o} == 5'b0,
                "reset_ctrl",
                {rd_req_o, tx_valid_o, tx_last_o, release_o, overflow_o}, 0);
            chk(q_count_o == 0 && tx_data_o == 0 && rd_addr_o == 0
                && release_ptr_o == 0, "reset_data", tx_data_o, 0);
            exp_frames.delete();
            exp_addr.delete();
            exp_words.delete();
            in_frame = 1'b0;
            prev_stall = 1'b0;
            prev_hdr_gnt = 1'b0;
        end else begin
            if (prev_stall)
                chk(tx_valid_o && tx_data_o == prev_data
                    && tx_last_o == prev_last, "tx_hold", tx_data_o, prev_data);
            if (prev_hdr_gnt)
                chk(!rd_req_o, "req_in_hdr_wait", rd_req_o, 0);
            prev_hdr_gnt = 1'b0;
            if (rd_req_o) begin
                if (!in_frame) begin
                    chk(exp_frames.size() != 0, "req_without_desc", rd_addr_o, 0);
                    if (exp_frames.size() != 0)
                        start_frame(exp_frames.pop_front());
                end
                chk(exp_addr.size() != 0, "req_unexpected", rd_addr_o, 0);
                if (exp_addr.size() != 0) begin
                    chk(rd_addr_o == exp_addr[0], "rd_addr", rd_addr_o, exp_addr[0]);
                    if (rd_gnt_i) begin
                        g_pend = 1'b1;
                        g_addr = rd_addr_o;
                        log_addr.push_back(rd_addr_o);
                        void'(exp_addr.pop_front());
                        if (rd_idx == 0) begin
                            prev_hdr_gnt = 1'b1;
                            hdr_gnt_cyc = cyc;
                        end
                        rd_idx++;
                    end
                end
            end
            if (tx_valid_o) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                chk(in_frame && exp_words.size() != 0, "tx_unexpected",
                    tx_data_o, 0);
                if (in_frame && exp_words.size() != 0 && tx_ready_i) begin
                    chk(tx_data_o == exp_words[0], "tx_data", tx_data_o, exp_words[0]);
                    chk(tx_last_o == (exp_words.size() == 1), "tx_last",
                        tx_last_o, exp_words.size() == 1);
                    log_words.push_back(tx_data_o);
                    void'(exp_words.pop_front());
                    beats++;
                end
            end
            if (in_frame && rd_idx > 1)
                chk(rd_idx - 1 - beats <= 2, "outstanding", rd_idx - 1 - beats, 2);
            if (release_o) begin
                rel_cyc = cyc;
                chk(in_frame && exp_words.size() == 0 && exp_addr.size() == 0,
                    "release_early", exp_words.size(), 0);
                chk(release_ptr_o == cur_ptr, "release_ptr", release_ptr_o, cur_ptr);
                log_rel.push_back(release_ptr_o);
                nrel++;
                in_frame = 1'b0;
            end
            if (overflow_o) begin
                novf++;
                ovf_cyc = cyc;
            end
            chk(q_count_o <= QD, "q_count_range", q_count_o, QD);
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_data = tx_data_o;
            prev_last = tx_last_o;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [AW-1:0] p, input int len,
                             input logic [DW-1:0] seed);
        logic [DW-1:0] hi;
        hi = DW'($urandom);
        mem[p] = {hi[DW-1:LW], LW'(len)};
        for (int k = 1; k <= len; k++)
            mem[AW'(p + AW'(k))] = (seed != 0) ? seed + DW'(k - 1) : DW'($urandom);
    endtask

    task automatic enq(input logic [AW-1:0] p, input bit acc);
        write_req_i = 1'b1;
        start_ptr_i = p;
        if (acc) exp_frames.push_back(p);
        tick();
        write_req_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int n;
        n = 0;
        while ((exp_frames.size() != 0 || in_frame) && n < budget) begin
            tick();
            n++;
        end
        chk(n < budget, nm, n, budget);
        tick(2);
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_words.delete();
        log_rel.delete();
    endtask

    task automatic chk_words(input logic [DW-1:0] seed, input int len, input string nm);
        chk(log_words.size() == len, nm, log_words.size(), len);
        for (int i = 0; i < len; i++)
            chk(log_words[i] == seed + DW'(i), nm, log_words[i], seed + DW'(i));
    endtask

    initial begin
        int c0;
        int n;
        logic [AW-1:0] wa [4];
        logic [AW-1:0] nxt;
        int len;

        write_req_i = 1'b0;
        start_ptr_i = '0;
        rd_gnt_i = 1'b0;
        rd_data_i = '0;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk(q_count_o == 0, "q_count_after_reset", q_count_o, 0);

        // single frame, latency, header upper bits ignored
        set_frame(10'h010, 3, 32'hA000_0001);
        mem[10'h010] = 32'hABCD_FC03;
        clear_logs();
        first_valid_cyc = -1;
        c0 = cyc;
        enq(10'h010, 1'b1);
        wait_drain(100, "drain_single");
        chk(first_valid_cyc - c0 == 5, "latency", first_valid_cyc - c0, 5);
        chk(log_addr.size() == 4, "single_nreads", log_addr.size(), 4);
        for (int i = 0; i < 4; i++)
            chk(log_addr[i] == AW'(10'h010 + i), "single_addr", log_addr[i], 10'h010 + i);
        chk_words(32'hA000_0001, 3, "single_words");
        chk(log_rel.size() == 1 && log_rel[0] == 10'h010, "single_rel", log_rel[0], 10'h010);

        // address wrap
        set_frame(10'h3FE, 3, 32'hB000_0000);
        clear_logs();
        enq(10'h3FE, 1'b1);
        wait_drain(100, "drain_wrap");
        wa[0] = 10'h3FE;
        wa[1] = 10'h3FF;
        wa[2] = 10'h000;
        wa[3] = 10'h001;
        for (int i = 0; i < 4; i++)
            chk(log_addr[i] == wa[i], "wrap_addr", log_addr[i], wa[i]);
        chk_words(32'hB000_0000, 3, "wrap_words");

        // zero length
        set_frame(10'h100, 0, 32'h0);
        clear_logs();
        enq(10'h100, 1'b1);
        wait_drain(100, "drain_zero");
        chk(log_words.size() == 0, "zero_no_tx", log_words.size(), 0);
        chk(rel_cyc - hdr_gnt_cyc == 2, "zero_rel_delay", rel_cyc - hdr_gnt_cyc, 2);
        chk(log_rel.size() == 1 && log_rel[0] == 10'h100, "zero_rel", log_rel[0], 10'h100);

        // backpressure
        rdy_mode = 1;
        set_frame(10'h120, 4, 32'hC000_0000);
        clear_logs();
        enq(10'h120, 1'b1);
        wait_drain(200, "drain_bp");
        chk_words(32'hC000_0000, 4, "bp_words");
        rdy_mode = 0;

        // overflow with the engine stalled on a header grant
        gnt_mode = 0;
        tick(2);
        set_frame(10'h200, 2, 32'h0);
        for (int i = 0; i < 9; i++) set_frame(AW'(10'h210 + 4 * i), 1, 32'h0);
        clear_logs();
        novf = 0;
        enq(10'h200, 1'b1);
        tick(2);
        chk(rd_req_o == 1'b1, "stall_hdr_req", rd_req_o, 1);
        c0 = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) c0 = cyc;
            enq(AW'(10'h210 + 4 * i), i < 8);
        end
        tick(2);
        chk(q_count_o == 8, "ovf_q_count", q_count_o, 8);
        chk(novf == 1, "ovf_pulses", novf, 1);
        chk(ovf_cyc == c0 + 1, "ovf_timing", ovf_cyc - c0, 1);
        gnt_mode = 1;
        wait_drain(400, "drain_ovf");
        chk(q_count_o == 0, "ovf_q_empty", q_count_o, 0);
        chk(log_rel.size() == 9, "ovf_releases", log_rel.size(), 9);

        // reset mid-frame after one beat
        set_frame(10'h300, 4, 32'hD000_0000);
        clear_logs();
        c0 = nrel;
        enq(10'h300, 1'b1);
        n = 0;
        while (log_words.size() < 1 && n < 50) begin
            tick();
            n++;
        end
        chk(n < 50, "wait_first_beat", n, 50);
        rst_n = 1'b0;
        chk(log_words.size() == 1, "beats_before_reset", log_words.size(), 1);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk(nrel == c0, "no_release_on_reset", nrel - c0, 0);
        set_frame(10'h320, 2, 32'hE000_0000);
        clear_logs();
        enq(10'h320, 1'b1);
        wait_drain(100, "drain_after_reset");
        chk_words(32'hE000_0000, 2, "post_reset_words");
        chk(log_rel.size() == 1 && log_rel[0] == 10'h320, "post_reset_rel",
            log_rel[0], 10'h320);

        // random traffic
        gnt_mode = 2;
        rdy_mode = 2;
        nxt = 10'h340;
        for (int f = 0; f < 120; f++) begin
            tick($urandom_range(0, 3));
            n = 0;
            while (exp_frames.size() + int'(in_frame) >= 5 && n < 500) begin
                tick();
                n++;
            end
            chk(n < 500, "rand_throttle", n, 500);
            len = $urandom_range(0, 12);
            set_frame(nxt, len, 32'h0);
            enq(nxt, 1'b1);
            nxt = AW'(nxt + AW'(len + 1 + $urandom_range(0, 2)));
        end
        wait_drain(3000, "drain_random");
        chk(q_count_o == 0, "final_q_empty", q_count_o, 0);
        chk(novf == 1, "overflow_total", novf, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #900000;
        nfail++;
        $display("FAIL watchdog: got timeout want completion (cycle %0d)", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
